chunked_alu: RTL and testbench

- Parametrised multi-cycle ALU. It processes WIDTH-bit operands CHUNK bits per cycle and ripples the carry between chunks through a register.
- It is the successor to the single-bit ALU slice, widened to full datapath width with flag outputs.
- It has the same operation encoding as the slice, with valid/ready handshakes on both the input and output sides.
- It sits between the register-file read stage and writeback for wide or low-area configurations.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_chunk.sv | 28 ++
 rtl/chunked_alu.sv | 140 ++++++++++++++
 tb/tb_chunked_alu.sv | 139 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: operation and state encodings shared by chunked_alu and alu_chunk.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_PASSB = 3'b000,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_AND   = 3'b100,
        OP_OR    = 3'b101,
        OP_XOR   = 3'b110
    } alu_op_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} alu_state_t;

    function automatic logic is_arith(input logic [2:0] op);
        return op == OP_ADD || op == OP_SUB;
    endfunction

endpackage

// File: rtl/alu_chunk.sv
// alu_chunk: combinational CHUNK-wide ALU slice; reserved encodings yield zero.
module alu_chunk import alu_pkg::*; #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             carry_i,
    input  logic             subtract_i,
    input  logic [2:0]       cntrl_i,
    output logic [CHUNK-1:0] res_o,
    output logic             carry_o,
    output logic             carry_msb_o
);
    logic [CHUNK-1:0] bx;
    logic [CHUNK:0]   sum;

    assign bx  = subtract_i ? ~b_i : b_i;
    assign sum = {1'b0, a_i} + {1'b0, bx} + {{CHUNK{1'b0}}, carry_i};
    assign carry_o = sum[CHUNK];
    // carry into the MSB recovered from the MSB sum bit and its two addends
    assign carry_msb_o = sum[CHUNK-1] ^ a_i[CHUNK-1] ^ bx[CHUNK-1];
    assign res_o = cntrl_i == OP_PASSB ? b_i :
                   is_arith(cntrl_i)   ? sum[CHUNK-1:0] :
                   cntrl_i == OP_AND   ? a_i & b_i :
                   cntrl_i == OP_OR    ? a_i | b_i :
                   cntrl_i == OP_XOR   ? a_i ^ b_i : '0;

endmodule

// File: rtl/chunked_alu.sv
// chunked_alu: multi-cycle ALU, CHUNK bits per cycle with a registered ripple carry.
// Define CHUNKED_ALU_FAST_LOGIC_EN to finish non-arithmetic ops in a single BUSY cycle.
module chunked_alu import alu_pkg::*; #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       cntrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;

    alu_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [2:0]       op_q, op_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d, neg_q, neg_d, zero_q, zero_d;
    logic             ovf_q, ovf_d, cout_q, cout_d;
    logic [31:0]      base;
    logic [CHUNK-1:0] chunk_res;
    logic             chunk_cout, chunk_cmsb, fin;

    assign base = 32'(idx_q) * CHUNK;

    alu_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a_i        (a_q[base +: CHUNK]),
        .b_i        (b_q[base +: CHUNK]),
        .carry_i    (carry_q),
        .subtract_i (op_q == OP_SUB),
        .cntrl_i    (op_q),
        .res_o      (chunk_res),
        .carry_o    (chunk_cout),
        .carry_msb_o(chunk_cmsb)
    );

`ifdef CHUNKED_ALU_FAST_LOGIC_EN
    logic [WIDTH-1:0] fast_res;
    assign fast_res = op_q == OP_PASSB ? b_q :
                      op_q == OP_AND   ? a_q & b_q :
                      op_q == OP_OR    ? a_q | b_q :
                      op_q == OP_XOR   ? a_q ^ b_q : '0;
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        result_d = result_q;
        neg_d    = neg_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        cout_d   = cout_q;
        fin      = 1'b0;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = a;
                b_d     = b;
                op_d    = cntrl;
                idx_d   = '0;
                carry_d = cntrl == OP_SUB;
                state_d = BUSY;
            end
            BUSY: begin
                result_d[base +: CHUNK] = chunk_res;
                carry_d = chunk_cout;
                idx_d   = idx_q + 1'b1;
                fin     = idx_q == IW'(NCHUNK - 1);
`ifdef CHUNKED_ALU_FAST_LOGIC_EN
                if (!is_arith(op_q)) begin
                    result_d = fast_res;
                    fin      = 1'b1;
                end
`endif
                if (fin) begin
                    // the last chunk's carries are those of the full-width MSB
                    state_d = DONE;
                    idx_d   = '0;
                    cout_d  = is_arith(op_q) & chunk_cout;
                    ovf_d   = is_arith(op_q) & (chunk_cmsb ^ chunk_cout);
                    neg_d   = result_d[WIDTH-1];
                    zero_d  = result_d == '0;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            cout_q   <= cout_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign result    = result_q;
    assign negative  = neg_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_chunked_alu.sv
// tb_chunked_alu: directed and randomized checks of chunked_alu against a full-width arithmetic model.
module tb_chunked_alu;
    localparam int WIDTH = 64;
    localparam int CHUNK = 16;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [WIDTH-1:0] a = '0, b = '0;
    logic [2:0]       cntrl = '0;
    logic             in_ready, out_valid, negative, zero, overflow, carry_out;
    logic [WIDTH-1:0] result;
    int               tests = 0, fails = 0;

    chunked_alu #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cntrl(cntrl), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .negative(negative), .zero(zero),
        .overflow(overflow), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Full-width reference: overflow from the signed-operand sign rule
    function automatic void model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic [2:0] op, output logic [WIDTH-1:0] r,
                                  output logic c, output logic v);
        logic [WIDTH:0]   s;
        logic [WIDTH-1:0] yy;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'b000: r = y;
            3'b010, 3'b011: begin
                yy = op[0] ? ~y : y;
                s  = {1'b0, x} + {1'b0, yy} + (WIDTH+1)'(op[0]);
                r  = s[WIDTH-1:0];
                c  = s[WIDTH];
                v  = (x[WIDTH-1] == yy[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
            end
            3'b100: r = x & y;
            3'b101: r = x | y;
            3'b110: r = x ^ y;
            default: r = '0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op);
`ifdef CHUNKED_ALU_FAST_LOGIC_EN
        if (!(op == 3'b010 || op == 3'b011)) return 1;
`endif
        return NCHUNK;
    endfunction

    task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb2,
                         input logic [2:0] op, input int hold, input bit poke);
        logic [WIDTH-1:0] r;
        logic             c, v;
        int               n;
        model(ta, tb2, op, r, c, v);
        @(negedge clk);
        a = ta; b = tb2; cntrl = op; in_valid = 1'b1; out_ready = 1'b0;
        check("in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; cntrl = 3'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, exp_lat(op));
        check("result", result, r);
        check("carry_out", carry_out, c);
        check("overflow", overflow, v);
        check("negative", negative, r[WIDTH-1]);
        check("zero", zero, r == '0);
        if (poke) in_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_result", result, r);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drain_valid", out_valid, 0);
        check("drain_in_ready", in_ready, 1);
        in_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 0);
        @(negedge clk);
        reset = 1'b0;
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 0, 1'b0);
        do_op(64'h8000_0000_0000_0000, 64'd1, 3'b011, 0, 1'b0);
        do_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 3'b110, 0, 1'b0);
        do_op(64'd5, 64'd7, 3'b010, 6, 1'b1);
        do_op(64'hFF, 64'hFF, 3'b001, 0, 1'b0);
        do_op(64'hFF, 64'hFF, 3'b111, 1, 1'b0);
        // reset during the second BUSY cycle
        @(negedge clk);
        a = 64'h1111; b = 64'h2222; cntrl = 3'b010; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        do_op(64'd3, 64'd4, 3'b010, 0, 1'b0);
        for (int k = 0; k < 40; k++)
            do_op({$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom_range(0, 7)),
                  $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
